// File: rtl/multi_act_scheduler.sv
// multi_act_scheduler
//   Places PRE, ACT r0, PRE, ACT r1, ..., ACT r(n-1), PRE for one bank into
//   the SLOTS-wide PHY command bundle. The ACT->PRE and PRE->ACT gaps are
//   programmable. Only the opening PRE, the final ACT and the closing PRE
//   are arbitrated through the command-timing (cdt) handshake. The middle
//   commands are placed purely by slot arithmetic.
//
// Ports
//   clk, rst          fabric clock, synchronous active-high reset
//   start, busy       request (sampled in IDLE) / not-idle flag
//   finish            one-cycle completion pulse
//   n_acts, rows      number of ACTs and their rows (row i in slice i)
//   bank_in           target bank
//   t_ap, t_pa        ACT->PRE / PRE->ACT gaps in slots (0 acts as 1)
//   keep_open         leave the last row open (no closing PRE)
//   row_miss          bank already closed, skip the opening PRE
//   phy_*             PHY bundle, slot i in slice i
//   pre, act          pulses for the bank state tracker
//   cmd, bank         command offered to the cdt
//   issue, issued_offset  cdt command accepted this cycle and its slot
//   offset, valid     earliest legal slot / permission from the cdt
module multi_act_scheduler #(
  parameter int SLOTS          = 4,
  parameter int MAX_ACTS       = 4,
  parameter int GAP_W          = 4,
  parameter int TRP_SLOTS      = 6,
  parameter int POS_W          = 6,
  parameter int DEC_DDR_CMD_SZ = 3,
  parameter int ROW_SZ         = 14,
  parameter int BANK_SZ        = 3,
  parameter int COL_SZ         = 10,
  parameter logic [DEC_DDR_CMD_SZ-1:0] DDR_NOP = 3'b111,
  parameter logic [DEC_DDR_CMD_SZ-1:0] DDR_ACT = 3'b011,
  parameter logic [DEC_DDR_CMD_SZ-1:0] DDR_PRE = 3'b010,
  localparam int NW = $clog2(MAX_ACTS + 1),
  localparam int SW = $clog2(SLOTS),
  localparam int KW = $clog2(2 * MAX_ACTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  output logic                             busy,
  output logic                             finish,
  input  logic [NW-1:0]                    n_acts,
  input  logic [MAX_ACTS*ROW_SZ-1:0]       rows,
  input  logic [BANK_SZ-1:0]               bank_in,
  input  logic [GAP_W-1:0]                 t_ap,
  input  logic [GAP_W-1:0]                 t_pa,
  input  logic                             keep_open,
  input  logic                             row_miss,
  output logic [SLOTS*DEC_DDR_CMD_SZ-1:0]  phy_cmd,
  output logic [SLOTS*ROW_SZ-1:0]          phy_row,
  output logic [SLOTS*BANK_SZ-1:0]         phy_bank,
  output logic [SLOTS*COL_SZ-1:0]          phy_col,
  output logic                             pre,
  output logic                             act,
  output logic [DEC_DDR_CMD_SZ-1:0]        cmd,
  output logic [BANK_SZ-1:0]               bank,
  output logic                             issue,
  output logic [SW-1:0]                    issued_offset,
  input  logic [SW-1:0]                    offset,
  input  logic                             valid
);

  typedef enum logic [1:0] {IDLE, OPEN, SEQ, CLOSE} state_t;

  state_t                            state;
  logic [POS_W-1:0]                  pos;
  logic [KW-1:0]                     k;
  logic [KW-1:0]                     last_q;
  logic [MAX_ACTS-1:0][ROW_SZ-1:0]   rows_q;
  logic [BANK_SZ-1:0]                bank_q;
  logic [GAP_W-1:0]                  t_ap_q, t_pa_q;
  logic                              keep_q;

  logic [NW-1:0]                     n_eff;
  logic [SLOTS-1:0][DEC_DDR_CMD_SZ-1:0] cmd_a;
  logic [SLOTS-1:0][ROW_SZ-1:0]      row_a;
  logic [SLOTS-1:0][BANK_SZ-1:0]     bank_a;
  logic [POS_W-1:0]                  p;
  logic [KW-1:0]                     kk;
  logic [SW-1:0]                     sl;
  logic                              done;
  logic                              last_hit;

  always_comb begin
    n_eff = n_acts;
    if (n_acts == '0)                  n_eff = NW'(1);
    else if (n_acts > NW'(MAX_ACTS))   n_eff = NW'(MAX_ACTS);
  end

  // Unrolled placement chain: each step places the pending command if its
  // position falls inside this cycle, then advances by the matching gap.
  always_comb begin
    for (int s = 0; s < SLOTS; s++) cmd_a[s] = DDR_NOP;
    row_a         = '0;
    bank_a        = '0;
    cmd           = DDR_NOP;
    bank          = '0;
    issue         = 1'b0;
    issued_offset = '0;
    pre           = 1'b0;
    act           = 1'b0;
    finish        = 1'b0;
    p             = pos;
    kk            = k;
    sl            = '0;
    done          = 1'b0;
    last_hit      = 1'b0;
    case (state)
      OPEN, CLOSE: begin
        cmd  = DDR_PRE;
        bank = bank_q;
        if (valid) begin
          cmd_a[offset]  = DDR_PRE;
          bank_a[offset] = bank_q;
          issue          = 1'b1;
          issued_offset  = offset;
          pre            = 1'b1;
          finish         = (state == CLOSE);
        end
      end
      SEQ: begin
        for (int s = 0; s < SLOTS; s++) begin
          if (!done && p < POS_W'(SLOTS)) begin
            sl         = p[SW-1:0];
            bank_a[sl] = bank_q;
            if (!kk[0]) begin
              cmd_a[sl] = DDR_ACT;
              row_a[sl] = rows_q[kk[KW-1:1]];
              p         = p + POS_W'(t_ap_q);
            end else begin
              cmd_a[sl] = DDR_PRE;
              p         = p + POS_W'(t_pa_q);
            end
            // final ACT goes through the cdt handshake
            if (kk == last_q) begin
              done          = 1'b1;
              last_hit      = 1'b1;
              cmd           = DDR_ACT;
              bank          = bank_q;
              issue         = 1'b1;
              issued_offset = sl;
              act           = 1'b1;
              finish        = keep_q;
            end
            kk = kk + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign phy_cmd  = cmd_a;
  assign phy_row  = row_a;
  assign phy_bank = bank_a;
  assign phy_col  = '0;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pos    <= '0;
      k      <= '0;
      last_q <= '0;
      rows_q <= '0;
      bank_q <= '0;
      t_ap_q <= '0;
      t_pa_q <= '0;
      keep_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          rows_q <= rows;
          bank_q <= bank_in;
          last_q <= KW'(2 * int'(n_eff) - 2);
          t_ap_q <= (t_ap == '0) ? GAP_W'(1) : t_ap;
          t_pa_q <= (t_pa == '0) ? GAP_W'(1) : t_pa;
          keep_q <= keep_open;
          pos    <= '0;
          k      <= '0;
          state  <= row_miss ? SEQ : OPEN;
        end
        OPEN: if (valid) begin
          // first ACT lands TRP_SLOTS after the PRE, measured from next cycle
          pos   <= POS_W'(offset) + POS_W'(TRP_SLOTS - SLOTS);
          k     <= '0;
          state <= SEQ;
        end
        SEQ: begin
          if (last_hit) state <= keep_q ? IDLE : CLOSE;
          pos <= p - POS_W'(SLOTS);
          k   <= kk;
        end
        CLOSE: if (valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_act_scheduler.sv
module tb_multi_act_scheduler;
  localparam int SLOTS = 4, MAX_ACTS = 4, GAP_W = 4, ROW_SZ = 14;
  localparam int BANK_SZ = 3, CW = 3, COL_SZ = 10;
  localparam logic [2:0] NOP = 3'b111, ACT = 3'b011, PRE = 3'b010;
  localparam logic [SLOTS*CW-1:0] ALL_NOP = {SLOTS{NOP}};

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic start, busy, finish, keep_open, row_miss, pre, act, issue, valid;
  logic [2:0] n_acts;
  logic [MAX_ACTS*ROW_SZ-1:0] rows;
  logic [BANK_SZ-1:0] bank_in, bank;
  logic [GAP_W-1:0] t_ap, t_pa;
  logic [SLOTS*CW-1:0] phy_cmd;
  logic [SLOTS*ROW_SZ-1:0] phy_row;
  logic [SLOTS*BANK_SZ-1:0] phy_bank;
  logic [SLOTS*COL_SZ-1:0] phy_col;
  logic [CW-1:0] cmd;
  logic [1:0] issued_offset, offset;

  multi_act_scheduler #(
    .SLOTS(SLOTS), .MAX_ACTS(MAX_ACTS), .GAP_W(GAP_W), .TRP_SLOTS(6), .POS_W(6),
    .DEC_DDR_CMD_SZ(CW), .ROW_SZ(ROW_SZ), .BANK_SZ(BANK_SZ), .COL_SZ(COL_SZ),
    .DDR_NOP(NOP), .DDR_ACT(ACT), .DDR_PRE(PRE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .finish(finish),
    .n_acts(n_acts), .rows(rows), .bank_in(bank_in), .t_ap(t_ap), .t_pa(t_pa),
    .keep_open(keep_open), .row_miss(row_miss), .phy_cmd(phy_cmd), .phy_row(phy_row),
    .phy_bank(phy_bank), .phy_col(phy_col), .pre(pre), .act(act), .cmd(cmd),
    .bank(bank), .issue(issue), .issued_offset(issued_offset), .offset(offset),
    .valid(valid)
  );

  typedef struct packed {
    logic [31:0]              cyc;
    logic [SLOTS*CW-1:0]      pcmd;
    logic [SLOTS*ROW_SZ-1:0]  prow;
    logic [SLOTS*BANK_SZ-1:0] pbank;
    logic [SLOTS*COL_SZ-1:0]  pcol;
    logic [CW-1:0]            cmd;
    logic [BANK_SZ-1:0]       bank;
    logic                     issue;
    logic [1:0]               ioff;
    logic                     pre, act, fin;
  } rec_t;

  rec_t q[$];
  rec_t e, mon_a, mon_x;
  int cyc = 0;
  int checks = 0, errors = 0;
  int s, c;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: any emitted slot or handshake pulse must match the next expectation
  always @(negedge clk) begin
    if (!rst) begin
      mon_a = {32'(cyc), phy_cmd, phy_row, phy_bank, phy_col, cmd, bank,
               issue, issued_offset, pre, act, finish};
      if (phy_cmd != ALL_NOP || issue || pre || act || finish) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got %h expected nothing", mon_a);
        end else begin
          mon_x = q.pop_front();
          if (mon_a !== mon_x) begin
            errors++;
            $display("FAIL cycle_%0d: got %h expected %h", mon_x.cyc, mon_a, mon_x);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] b);
    checks++;
    if (a !== b) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, b);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic e_new(input int cy);
    e = '0;
    e.cyc = 32'(cy);
    e.pcmd = ALL_NOP;
    e.cmd = NOP;
  endtask

  task automatic e_slot(input int sl, input logic [2:0] cc, input logic [ROW_SZ-1:0] r,
                        input logic [BANK_SZ-1:0] b);
    e.pcmd[sl*CW +: CW] = cc;
    e.prow[sl*ROW_SZ +: ROW_SZ] = r;
    e.pbank[sl*BANK_SZ +: BANK_SZ] = b;
  endtask

  task automatic e_cdt(input logic [2:0] cc, input logic [BANK_SZ-1:0] b, input logic iss,
                       input logic [1:0] io, input logic pr, input logic ac, input logic fi);
    e.cmd = cc; e.bank = b; e.issue = iss; e.ioff = io; e.pre = pr; e.act = ac; e.fin = fi;
  endtask

  task automatic e_push();
    q.push_back(e);
  endtask

  // issues start in the current cycle; returns one cycle later with start low
  task automatic go(input logic miss, input logic [2:0] n, input logic [3:0] ap,
                    input logic [3:0] pa, input logic keep, input logic [2:0] b,
                    input logic [ROW_SZ-1:0] r0, input logic [ROW_SZ-1:0] r1,
                    input logic [ROW_SZ-1:0] r2);
    row_miss = miss; n_acts = n; t_ap = ap; t_pa = pa; keep_open = keep; bank_in = b;
    rows = {ROW_SZ'(0), r2, r1, r0};
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic idle_chk(input string nm);
    @(negedge clk);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_phy"}, 64'(phy_cmd), 64'(ALL_NOP));
    chk({nm, "_cdt"}, {cmd, bank, issue, pre, act, finish}, {NOP, 3'd0, 4'd0});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 0; n_acts = 0; rows = '0; bank_in = 0; t_ap = 0; t_pa = 0;
    keep_open = 0; row_miss = 0; offset = 0; valid = 0;
    repeat (3) step();
    rst = 1'b0;
    idle_chk("reset");

    // row conflict, n=2, gaps 2, close at offset 2
    step(); s = cyc;
    go(0, 3'd2, 4'd2, 4'd2, 0, 3'd5, 14'h111, 14'h222, 14'h0);
    c = s + 1; valid = 1; offset = 2'd1;
    e_new(c);   e_slot(1, PRE, 0, 5); e_cdt(PRE, 5, 1, 1, 1, 0, 0); e_push();
    e_new(c+1); e_slot(3, ACT, 14'h111, 5); e_push();
    e_new(c+2); e_slot(1, PRE, 0, 5); e_slot(3, ACT, 14'h222, 5);
                e_cdt(ACT, 5, 1, 3, 0, 1, 0); e_push();
    e_new(c+3); e_slot(2, PRE, 0, 5); e_cdt(PRE, 5, 1, 2, 1, 0, 1); e_push();
    @(negedge clk); chk("t1_busy", 64'(busy), 64'd1);
    step(); valid = 0;
    step(); step(); valid = 1; offset = 2'd2;
    step(); valid = 0;
    @(negedge clk); chk("t1_done_busy", 64'(busy), 64'd0);

    // row_miss, n=3, gaps 1, keep_open
    step(); s = cyc;
    go(1, 3'd3, 4'd1, 4'd1, 1, 3'd3, 14'h0A1, 14'h0B2, 14'h0C3);
    e_new(s+1); e_slot(0, ACT, 14'h0A1, 3); e_slot(1, PRE, 0, 3);
                e_slot(2, ACT, 14'h0B2, 3); e_slot(3, PRE, 0, 3); e_push();
    e_new(s+2); e_slot(0, ACT, 14'h0C3, 3); e_cdt(ACT, 3, 1, 0, 0, 1, 1); e_push();
    step(); step();
    @(negedge clk); chk("t2_done_busy", 64'(busy), 64'd0);

    // n=0 and zero gaps behave as one ACT, then closing PRE
    step(); s = cyc;
    go(1, 3'd0, 4'd0, 4'd0, 0, 3'd6, 14'h3FF, 14'h1, 14'h2);
    e_new(s+1); e_slot(0, ACT, 14'h3FF, 6); e_cdt(ACT, 6, 1, 0, 0, 1, 0); e_push();
    step(); valid = 1; offset = 2'd3;
    e_new(s+2); e_slot(3, PRE, 0, 6); e_cdt(PRE, 6, 1, 3, 1, 0, 1); e_push();
    step(); valid = 0;
    step();
    @(negedge clk); chk("t3_done_busy", 64'(busy), 64'd0);

    // large gaps: ACT abs 4, PRE abs 19, ACT abs 28
    step(); s = cyc;
    go(1, 3'd2, 4'd15, 4'd9, 1, 3'd2, 14'h1234, 14'h2345, 14'h0);
    e_new(s+1); e_slot(0, ACT, 14'h1234, 2); e_push();
    e_new(s+4); e_slot(3, PRE, 0, 2); e_push();
    e_new(s+7); e_slot(0, ACT, 14'h2345, 2); e_cdt(ACT, 2, 1, 0, 0, 1, 1); e_push();
    repeat (8) step();
    @(negedge clk); chk("t4_done_busy", 64'(busy), 64'd0);

    // OPEN with valid low for 5 cycles, starts ignored
    step(); s = cyc;
    go(0, 3'd2, 4'd1, 4'd1, 0, 3'd4, 14'h0AA, 14'h0BB, 14'h0);
    for (int i = 0; i < 5; i++) begin
      start = (i == 1 || i == 3);
      row_miss = 1; n_acts = 3'd4; bank_in = 3'd7;
      @(negedge clk);
      chk($sformatf("t5_cmd_%0d", i), 64'(cmd), 64'(PRE));
      chk($sformatf("t5_busy_%0d", i), 64'(busy), 64'd1);
      step();
    end
    start = 0; c = cyc; valid = 1; offset = 2'd3;
    e_new(c);   e_slot(3, PRE, 0, 4); e_cdt(PRE, 4, 1, 3, 1, 0, 0); e_push();
    e_new(c+2); e_slot(1, ACT, 14'h0AA, 4); e_slot(2, PRE, 0, 4);
                e_slot(3, ACT, 14'h0BB, 4); e_cdt(ACT, 4, 1, 3, 0, 1, 0); e_push();
    e_new(c+3); e_slot(0, PRE, 0, 4); e_cdt(PRE, 4, 1, 0, 1, 0, 1); e_push();
    step(); valid = 0;
    step(); step(); valid = 1; offset = 2'd0;
    step(); valid = 0;
    @(negedge clk); chk("t5_done_busy", 64'(busy), 64'd0);

    // reset during SEQ after the first ACT, then a clean sequence
    step(); s = cyc;
    go(1, 3'd2, 4'd15, 4'd1, 1, 3'd1, 14'h055, 14'h066, 14'h0);
    e_new(s+1); e_slot(0, ACT, 14'h055, 1); e_push();
    step(); rst = 1;
    step(); rst = 0;
    idle_chk("t6_rst");
    step(); s = cyc;
    go(1, 3'd2, 4'd1, 4'd1, 1, 3'd2, 14'h077, 14'h088, 14'h0);
    e_new(s+1); e_slot(0, ACT, 14'h077, 2); e_slot(1, PRE, 0, 2);
                e_slot(2, ACT, 14'h088, 2); e_cdt(ACT, 2, 1, 2, 0, 1, 1); e_push();
    step(); step();
    @(negedge clk); chk("t6_done_busy", 64'(busy), 64'd0);

    repeat (5) step();
    chk("drain_pending", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
